// File: rtl/prach_obuf.sv
// PRACH DDC output buffer: pairs hb5 I/Q beats into tagged 32-bit words, frames each channel, FWFT FIFO out.
// Optional PRACH_OBUF_STAT_EN adds stat_words / stat_maxlvl counters.
module prach_obuf #(
    parameter int NUM_CHN    = 8,
    parameter int FRAME_LEN  = 1024,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [15:0]                   din_dq,
    input  logic                          din_dv,
    input  logic [7:0]                    din_chn,
    input  logic                          sync_in,
    output logic [31:0]                   m_tdata,
    output logic [7:0]                    m_tuser,
    output logic                          m_tlast,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    input  logic                          clr_stat,
    output logic                          stat_ovf,
    output logic                          stat_iqerr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef PRACH_OBUF_STAT_EN
    ,
    output logic [31:0]                   stat_words,
    output logic [$clog2(FIFO_DEPTH):0]   stat_maxlvl
`endif
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FRAME_LEN);
    localparam int CHW = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;
    localparam logic [7:0]    NCHN     = 8'(NUM_CHN);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);
    localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {PH_I = 1'b0, PH_Q = 1'b1} phase_t;

    phase_t          phase, phase_eff, phase_nxt;
    logic [15:0]     lat_i;
    logic [7:0]      lat_chn;
    logic [CW-1:0]   cnt [NUM_CHN];
    logic [CHW-1:0]  cidx;
    logic [CW-1:0]   cur_cnt;
    logic            q_beat, lat_ok, req, iq_set;

    logic            wr_req;
    logic [40:0]     wr_ent;
    logic [40:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            full, do_wr, do_rd;

    // sync_in acts before the beat in the same cycle, so that beat is always an I beat
    always_comb begin
        phase_eff = sync_in ? PH_I : phase;
        phase_nxt = phase_eff;
        if (din_dv)
            phase_nxt = (phase_eff == PH_I) ? PH_Q : PH_I;
        q_beat  = din_dv && (phase_eff == PH_Q);
        lat_ok  = lat_chn < NCHN;
        req     = q_beat && lat_ok;
        cidx    = lat_chn[CHW-1:0];
        cur_cnt = cnt[cidx];
        iq_set  = (din_dv && (din_chn >= NCHN)) ||
                  (q_beat && ((din_chn != lat_chn) || !lat_ok));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            phase <= PH_I;
        else
            phase <= phase_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_i   <= '0;
            lat_chn <= '0;
            wr_req  <= 1'b0;
            wr_ent  <= '0;
            for (int unsigned i = 0; i < NUM_CHN; i++)
                cnt[i] <= '0;
        end else begin
            if (din_dv && (phase_eff == PH_I)) begin
                lat_i   <= din_dq;
                lat_chn <= din_chn;
            end
            // request is registered so full is judged one cycle later against the stored level
            wr_req <= req;
            if (req)
                wr_ent <= {(cur_cnt == LAST_CNT), lat_chn, din_dq, lat_i};
            if (sync_in) begin
                for (int unsigned i = 0; i < NUM_CHN; i++)
                    cnt[i] <= '0;
            end else if (req) begin
                cnt[cidx] <= (cur_cnt == LAST_CNT) ? '0 : cur_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        full     = (fifo_level == DEPTH);
        do_wr    = wr_req && !full;
        m_tvalid = (fifo_level != '0);
        do_rd    = m_tvalid && m_tready;
        {m_tlast, m_tuser, m_tdata} = m_tvalid ? mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= wr_ent;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // set events take priority over clr_stat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ovf   <= 1'b0;
            stat_iqerr <= 1'b0;
        end else begin
            if (wr_req && full)
                stat_ovf <= 1'b1;
            else if (clr_stat)
                stat_ovf <= 1'b0;
            if (iq_set)
                stat_iqerr <= 1'b1;
            else if (clr_stat)
                stat_iqerr <= 1'b0;
        end
    end

`ifdef PRACH_OBUF_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_words  <= '0;
            stat_maxlvl <= '0;
        end else if (clr_stat) begin
            stat_words  <= '0;
            stat_maxlvl <= '0;
        end else begin
            if (do_wr)
                stat_words <= stat_words + 1'b1;
            if (fifo_level > stat_maxlvl)
                stat_maxlvl <= fifo_level;
        end
    end
`endif

endmodule

// File: tb/tb_prach_obuf.sv
// Self-checking bench for prach_obuf (FRAME_LEN=4, FIFO_DEPTH=4): scoreboard of expected words plus directed checks.
module tb_prach_obuf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din_dq;
    logic        din_dv;
    logic [7:0]  din_chn;
    logic        sync_in;
    logic [31:0] m_tdata;
    logic [7:0]  m_tuser;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic        clr_stat;
    logic        stat_ovf;
    logic        stat_iqerr;
    logic [2:0]  fifo_level;
`ifdef PRACH_OBUF_STAT_EN
    logic [31:0] stat_words;
    logic [2:0]  stat_maxlvl;
`endif

    prach_obuf #(.NUM_CHN(8), .FRAME_LEN(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .din_dq(din_dq), .din_dv(din_dv), .din_chn(din_chn),
        .sync_in(sync_in), .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .clr_stat(clr_stat),
        .stat_ovf(stat_ovf), .stat_iqerr(stat_iqerr), .fifo_level(fifo_level)
`ifdef PRACH_OBUF_STAT_EN
        , .stat_words(stat_words), .stat_maxlvl(stat_maxlvl)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  chn;
        logic [15:0] i;
        logic [15:0] q;
        logic        last;
    } vec_t;

    vec_t        tbl [16];
    logic [40:0] sb [$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // one clock: sample/score output at negedge, return 1 time unit after the posedge
    task automatic step();
        @(negedge clk);
        if (rst_n && m_tvalid && m_tready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %h required none", {m_tlast, m_tuser, m_tdata});
            end else begin
                chk("word", {23'h0, m_tlast, m_tuser, m_tdata}, {23'h0, sb.pop_front()});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input logic [7:0] ci, input logic [15:0] di,
                             input logic [7:0] cq, input logic [15:0] dq,
                             input bit push, input logic last);
        din_dv  = 1'b1;
        din_chn = ci;
        din_dq  = di;
        step();
        din_chn = cq;
        din_dq  = dq;
        if (push)
            sb.push_back({last, ci, dq, di});
        step();
        din_dv = 1'b0;
    endtask

    task automatic pulse_sync();
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sb.size() != 0; k++)
            step();
        chk("drain_left", 64'(sb.size()), 64'd0);
        step();
        step();
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            tbl[2*k]   = '{chn: 8'd0, i: 16'h0100 + 16'(k), q: 16'h0200 + 16'(k), last: (k == 3 || k == 7)};
            tbl[2*k+1] = '{chn: 8'd1, i: 16'h0300 + 16'(k), q: 16'h0400 + 16'(k), last: (k == 3 || k == 7)};
        end

        rst_n = 1'b0; din_dq = '0; din_dv = 1'b0; din_chn = '0;
        sync_in = 1'b0; m_tready = 1'b0; clr_stat = 1'b0;
        step();
        step();
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_tdata", 64'({m_tlast, m_tuser, m_tdata}), 64'd0);
        chk("rst_flags", 64'({stat_ovf, stat_iqerr}), 64'd0);
        rst_n = 1'b1;
        step();

        // basic pair and latency
        m_tready = 1'b1;
        send_pair(8'd3, 16'h1234, 8'd3, 16'hABCD, 1'b1, 1'b0);
        chk("lat_n1_tvalid", 64'(m_tvalid), 64'd0);
        step();
        chk("lat_n2_tvalid", 64'(m_tvalid), 64'd1);
        chk("basic_tdata", 64'(m_tdata), 64'hABCD1234);
        chk("basic_tuser", 64'(m_tuser), 64'd3);
        chk("basic_tlast", 64'(m_tlast), 64'd0);
        drain();

        // framing over two interleaved channels
        pulse_sync();
        for (int v = 0; v < 16; v++)
            send_pair(tbl[v].chn, tbl[v].i, tbl[v].chn, tbl[v].q, 1'b1, tbl[v].last);
        drain();
        chk("frame_flags", 64'({stat_ovf, stat_iqerr}), 64'd0);

        // sync coincident with an I beat after two pairs
        send_pair(8'd0, 16'h0A00, 8'd0, 16'h0B00, 1'b1, 1'b0);
        send_pair(8'd0, 16'h0A01, 8'd0, 16'h0B01, 1'b1, 1'b0);
        sync_in = 1'b1; din_dv = 1'b1; din_chn = 8'd0; din_dq = 16'h0A02;
        step();
        sync_in = 1'b0; din_dq = 16'h0B02;
        sb.push_back({1'b0, 8'd0, 16'h0B02, 16'h0A02});
        step();
        din_dv = 1'b0;
        send_pair(8'd0, 16'h0A03, 8'd0, 16'h0B03, 1'b1, 1'b0);
        send_pair(8'd0, 16'h0A04, 8'd0, 16'h0B04, 1'b1, 1'b0);
        send_pair(8'd0, 16'h0A05, 8'd0, 16'h0B05, 1'b1, 1'b1);
        // half pair discarded by a standalone sync
        din_dv = 1'b1; din_chn = 8'd0; din_dq = 16'hDEAD;
        step();
        din_dv = 1'b0;
        pulse_sync();
        send_pair(8'd0, 16'h1111, 8'd0, 16'h2222, 1'b1, 1'b0);
        drain();

        // backpressure and overflow
        m_tready = 1'b0;
        pulse_sync();
        for (int p = 0; p < 6; p++)
            send_pair(8'd1, 16'h5000 + 16'(p), 8'd1, 16'h6000 + 16'(p), p < 4, p == 3);
        step();
        step();
        chk("ovf_level", 64'(fifo_level), 64'd4);
        chk("ovf_flag", 64'(stat_ovf), 64'd1);
        chk("ovf_tvalid_held", 64'(m_tvalid), 64'd1);
        chk("ovf_head_held", 64'(m_tdata), 64'h60005000);
        m_tready = 1'b1;
        drain();
        chk("ovf_level_drained", 64'(fifo_level), 64'd0);
        clr_stat = 1'b1;
        step();
        clr_stat = 1'b0;
        chk("ovf_cleared", 64'(stat_ovf), 64'd0);

        // I/Q channel mismatch and invalid channel
        pulse_sync();
        send_pair(8'd2, 16'h5555, 8'd5, 16'h6666, 1'b1, 1'b0);
        chk("iqerr_set", 64'(stat_iqerr), 64'd1);
        clr_stat = 1'b1;
        step();
        clr_stat = 1'b0;
        chk("iqerr_cleared", 64'(stat_iqerr), 64'd0);
        send_pair(8'd9, 16'h7777, 8'd9, 16'h8888, 1'b0, 1'b0);
        chk("badchn_iqerr", 64'(stat_iqerr), 64'd1);
        send_pair(8'd2, 16'h0C01, 8'd2, 16'h0D01, 1'b1, 1'b0);
        send_pair(8'd2, 16'h0C02, 8'd2, 16'h0D02, 1'b1, 1'b0);
        send_pair(8'd2, 16'h0C03, 8'd2, 16'h0D03, 1'b1, 1'b1);
        drain();

        // reset mid-stream with words queued and a half pair pending
        m_tready = 1'b0;
        for (int p = 0; p < 3; p++)
            send_pair(8'd4, 16'h3000 + 16'(p), 8'd4, 16'h4000 + 16'(p), 1'b0, 1'b0);
        din_dv = 1'b1; din_chn = 8'd4; din_dq = 16'hBEEF;
        step();
        din_dv = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("mrst_tvalid", 64'(m_tvalid), 64'd0);
        chk("mrst_level", 64'(fifo_level), 64'd0);
        chk("mrst_flags", 64'({stat_ovf, stat_iqerr}), 64'd0);
        m_tready = 1'b1;
        send_pair(8'd4, 16'h7700, 8'd4, 16'h8800, 1'b1, 1'b0);
        send_pair(8'd4, 16'h7701, 8'd4, 16'h8801, 1'b1, 1'b0);
        send_pair(8'd4, 16'h7702, 8'd4, 16'h8802, 1'b1, 1'b0);
        send_pair(8'd4, 16'h7703, 8'd4, 16'h8803, 1'b1, 1'b1);
        drain();
        chk("final_level", 64'(fifo_level), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
